uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter with an integrated baud divider and transmit FIFO, replacing the fixed 8N1 transmitter/baud-generator pair. Software pushes bytes into a FIFO; a frame engine serialises them with runtime-selectable data width (5–8 bits), parity (none/odd/even) and stop bits (1/2). The block sits between the register-interface bus logic and the TX pin.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz; informational, used only by bench checks.
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, 2..256.
- DIV_W, 16, width of the baud divisor.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_div  input  DIV_W  clock cycles per bit minus 1; bit period = baud_div+1 cycles.
- data_bits  input  2  data length: 0→5, 1→6, 2→7, 3→8 bits.
- parity_mode  input  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  input  1  0 → one stop bit, 1 → two.
- wr_en  input  1  push wr_data into FIFO.
- wr_data  input  8  byte to send; bits above data length ignored.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds no entries.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  output  1  frame engine not in IDLE.
- tx  output  1  serial line, idle high.

## Operation
- FIFO: circular buffer, read/write pointers one bit wider than address. Push when wr_en && !full; wr_en while full is dropped, no state change. Pop by frame engine only. Push and pop in the same cycle: level unchanged, both pointers advance; legal also when full.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If !empty: pop head into shift register, latch baud_div/data_bits/parity_mode/stop_bits into frame registers, clear bit counter, go START. Input changes mid-frame take effect at next frame.
- Bit timer: counts 0..baud_div; terminal count ends the current bit and resets to 0.
- START: tx=0 for one bit period → DATA.
- DATA: tx = shift[0], LSB first; shift right at each bit end; after data_bits+5 bits → PARITY if parity enabled, else STOP.
- PARITY: odd → tx = ~^data; even → tx = ^data, over sent bits only → STOP.
- STOP: tx=1 for 1 or 2 bit periods. At end: if !empty, pop and go directly to START (no idle gap); else IDLE.
- Frame length = (1 + N + P + S)·(baud_div+1) cycles, N=data bits, P∈{0,1}, S∈{1,2}.
- baud_div = 0: one bit per clock, legal.

## Timing
- Reset values: tx=1, busy=0, empty=1, full=0, level=0, state IDLE, pointers and timer 0. Reset mid-frame returns tx to 1 asynchronously; FIFO contents discarded.
- Push at edge k: level/empty/full update after edge k.
- Write to empty FIFO while IDLE at edge k: pop and tx falls after edge k+1; busy rises same edge.
- All outputs registered; tx has no combinational path from inputs.
- busy falls on the edge where the last stop bit ends with FIFO empty.

## Configuration
- UART_TX_BREAK_EN: adds input port break_req (1 bit). When defined, break_req high forces tx=0 the cycle after sampling, overriding the frame engine; FSM and FIFO freeze (no pops, timer holds) until release, then the interrupted bit restarts from timer 0. When undefined, port absent and tx driven solely by the FSM.

## Test plan
- Reset: assert rst mid-frame at baud_div=3 → tx=1, busy=0, empty=1, level=0 immediately; no further activity.
- 8N1, baud_div=9, push 0xA5 → tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10; total 100 cycles; busy falls after.
- 7E2, baud_div=0, push 0x53 → start, bits 1,1,0,0,1,0,1, parity 0, two stop bits; 11 cycles total; bit 7 of input ignored.
- 5O1, push 0x00 → five zeros then parity 1; 6N1 for 0x3F → parity state skipped.
- FIFO: push 17 bytes back-to-back at DEPTH=16 while engine busy → full after 16th push, 17th dropped, level peaks 16; frames emitted back-to-back with no idle cycles, in order.
- Change data_bits/baud_div mid-frame → current frame unchanged, next frame uses new settings.

Source files
------------

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//   Parametrised UART transmitter: transmit FIFO, baud divider and frame
//   engine with runtime-selectable data width (5-8), parity (none/odd/even)
//   and stop bits (1/2). Frame settings are latched when a byte is popped,
//   so input changes mid-frame apply to the next frame only.
//
// Parameters
//   CLK_FREQ   : system clock in Hz (informational only)
//   FIFO_DEPTH : transmit FIFO entries, power of two, 2..256
//   DIV_W      : baud divisor width
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   baud_div          : cycles per bit minus 1
//   data_bits         : 0..3 -> 5..8 data bits
//   parity_mode       : 00 none, 01 odd, 10 even, 11 none
//   stop_bits         : 0 -> one stop bit, 1 -> two
//   wr_en, wr_data    : FIFO push (dropped when full unless popping)
//   full, empty, level: FIFO status (registered)
//   busy              : frame engine not idle
//   tx                : serial line, idle high
//
// Optional feature (macro UART_TX_BREAK_EN)
//   Adds input break_req. While the registered break_req is high, tx is
//   held low, the FSM and FIFO pop are frozen and the bit timer is held at
//   0, so the interrupted bit restarts in full on release.
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
      || CLK_FREQ <= 0) begin : g_bad_cfg
    $error("uart_tx_param: illegal FIFO_DEPTH or CLK_FREQ");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_full, r_empty;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt;
  logic          w_push, w_pop;

  // ---------------------------------------------------------------- engine
  state_t           r_state;
  logic [DIV_W-1:0] r_timer, r_div;
  logic [1:0]       r_nbits;
  logic             r_par_en, r_par_bit, r_two_stop;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             r_tx, r_busy;

  logic       w_run, w_bit_end, w_last_data, w_stop_last, w_load;
  logic [7:0] w_head, w_data_m;
  logic       w_par;

`ifdef UART_TX_BREAK_EN
  logic r_brk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_brk <= 1'b0;
    else     r_brk <= break_req;
  end
  assign w_run = ~r_brk;
  assign tx    = r_tx & ~r_brk;
`else
  assign w_run = 1'b1;
  assign tx    = r_tx;
`endif

  always_comb begin
    w_head      = r_mem[r_rd_ptr[AW-1:0]];
    // Data bits above the selected length are cleared so the parity over
    // the whole byte equals the parity over the bits actually sent.
    w_data_m    = w_head & (8'hFF >> (2'd3 - data_bits));
    w_par       = (parity_mode == 2'b01) ? ~^w_data_m : ^w_data_m;
    w_bit_end   = (r_timer == r_div);
    w_last_data = (r_bitcnt == (3'(r_nbits) + 3'd4));
    w_stop_last = w_bit_end && (r_bitcnt[0] == r_two_stop);
    w_load      = w_run && !r_empty &&
                  ((r_state == S_IDLE) || (r_state == S_STOP && w_stop_last));
    w_pop       = w_load;
    // A pop in the same cycle frees a slot, so a push while full is accepted.
    w_push      = wr_en && (!r_full || w_pop);
    w_wr_nxt    = r_wr_ptr + PW'(w_push);
    w_rd_nxt    = r_rd_ptr + PW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_wr_nxt - w_rd_nxt;
      r_full   <= ((w_wr_nxt - w_rd_nxt) == PW'(FIFO_DEPTH));
      r_empty  <= (w_wr_nxt == w_rd_nxt);
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_div      <= '0;
      r_nbits    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else if (!w_run) begin
      r_timer <= '0;
    end else if (w_load) begin
      // Entered from IDLE or straight from the last stop bit (no idle gap).
      r_state    <= S_START;
      r_timer    <= '0;
      r_div      <= baud_div;
      r_nbits    <= data_bits;
      r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      r_par_bit  <= w_par;
      r_two_stop <= stop_bits;
      r_bitcnt   <= '0;
      r_shift    <= w_data_m;
      r_tx       <= 1'b0;
      r_busy     <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else if (!w_bit_end) begin
      r_timer <= r_timer + DIV_W'(1);
    end else begin
      r_timer <= '0;
      case (r_state)
        S_START: begin
          r_state <= S_DATA;
          r_tx    <= r_shift[0];
        end
        S_DATA: begin
          r_shift <= r_shift >> 1;
          if (w_last_data) begin
            r_bitcnt <= '0;
            if (r_par_en) begin
              r_state <= S_PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_tx     <= r_shift[1];
          end
        end
        S_PARITY: begin
          r_state  <= S_STOP;
          r_bitcnt <= '0;
          r_tx     <= 1'b1;
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (r_bitcnt[0] == r_two_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_bitcnt <= 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign level = r_level;
  assign busy  = r_busy;

endmodule
